// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1, majority-of-three bit sampling, single-entry holding register.
// Byte is presented one clk after the stop-bit mid sample; the line is never back-pressured, so a held byte forces a drop and raises overrun.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_clk,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [1:0]             smp_q, smp_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;

    logic rx_s;
    logic maj;
    logic frame_done;
    logic accept;

    assign rx_s   = sync_q[SYNC_STAGES-1];
    // Third sample is the live line value at the decision tick.
    assign maj    = (smp_q[0] & smp_q[1]) | (rx_s & (smp_q[0] | smp_q[1]));
    assign accept = valid_q & ready;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        ferr_d     = 1'b0;
        frame_done = 1'b0;

        if (enable_clk && state_q != S_IDLE) begin
            tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
            if (tick_q == T_LO)  smp_d[0] = rx_s;
            if (tick_q == T_MID) smp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = '0;
                if (enable_clk && !rx_s) state_d = S_START;
            end
            S_START: begin
                if (enable_clk) begin
                    if (tick_q == T_HI && maj) begin
                        state_d = S_IDLE;
                        tick_d  = '0;
                    end else if (tick_q == T_LAST) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (enable_clk) begin
                    if (tick_q == T_HI) shift_d = {maj, shift_q[7:1]};
                    if (tick_q == T_LAST) begin
                        if (bit_q == 3'd7) state_d = S_STOP;
                        else               bit_d   = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (enable_clk && tick_q == T_HI) begin
                    tick_d = '0;
                    if (maj) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                tick_d = '0;
                if (enable_clk && rx_s) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Holding register: a completed frame loads only if the slot is empty or being emptied this edge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (frame_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            smp_q   <= 2'b00;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
